// File: rtl/calc_entry_core.sv
// Decimal-entry calculator core: digit-by-digit operand entry, pending-operator
// chaining and a registered unsigned result with a sticky overflow flag.
module calc_entry_core #(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = 9,
  parameter int ENABLE_MUL = 1
) (
  input  logic              CLK_100MHZ,
  input  logic              reset,
  input  logic              digit_valid,
  input  logic [3:0]        digit,
  input  logic              op_valid,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] entry,
  output logic [3:0]        digit_count,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam logic [1:0] S_ENTRY_A = 2'd0;
  localparam logic [1:0] S_OP_WAIT = 2'd1;
  localparam logic [1:0] S_ENTRY_B = 2'd2;
  localparam logic [1:0] S_SHOW    = 2'd3;

  localparam logic [1:0] PEND_ADD = 2'd0;
  localparam logic [1:0] PEND_SUB = 2'd1;
  localparam logic [1:0] PEND_MUL = 2'd2;

  logic [DATA_W-1:0] entry_q, entry_d;
  logic [3:0]        count_q, count_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              resValid_q, resValid_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        state_q, state_d;

  logic              isArith, isEquals, isClear;
  logic [1:0]        newPend;
  logic              digitLegal, roomLeft;
  logic [DATA_W-1:0] appendVal;
  logic [DATA_W:0]   sumW, diffW;
  logic [2*DATA_W-1:0] prodW;
  logic [DATA_W-1:0] calcVal;
  logic              calcOvf;

  // A digit arriving together with any op strobe is dropped in favour of the op.
  always_comb begin
    isArith    = op_valid && ((op == 3'd0) || (op == 3'd1) ||
                              ((op == 3'd2) && (ENABLE_MUL != 0)));
    isEquals   = op_valid && (op == 3'd3);
    isClear    = op_valid && (op == 3'd4);
    newPend    = op[1:0];
    digitLegal = digit_valid && !op_valid && (digit <= 4'd9);
    roomLeft   = (count_q < 4'(MAX_DIGITS));
    appendVal  = entry_q * DATA_W'(10) + DATA_W'(digit);
  end

  always_comb begin
    sumW    = {1'b0, acc_q} + {1'b0, entry_q};
    diffW   = {1'b0, acc_q} - {1'b0, entry_q};
    prodW   = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, entry_q};
    calcVal = sumW[DATA_W-1:0];
    calcOvf = sumW[DATA_W];
    case (pend_q)
      PEND_SUB: begin
        calcVal = diffW[DATA_W-1:0];
        calcOvf = diffW[DATA_W];
      end
      PEND_MUL: begin
        calcVal = prodW[DATA_W-1:0];
        calcOvf = |prodW[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    entry_d    = entry_q;
    count_d    = count_q;
    acc_d      = acc_q;
    result_d   = result_q;
    resValid_d = 1'b0;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    state_d    = state_q;

    if (digitLegal) begin
      case (state_q)
        S_ENTRY_A, S_ENTRY_B: begin
          if (roomLeft) begin
            entry_d = appendVal;
            count_d = count_q + 4'd1;
          end
        end
        S_OP_WAIT: begin
          entry_d = DATA_W'(digit);
          count_d = 4'd1;
          state_d = S_ENTRY_B;
        end
        default: begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          entry_d = DATA_W'(digit);
          count_d = 4'd1;
          state_d = S_ENTRY_A;
        end
      endcase
    end

    if (isClear) begin
      entry_d  = '0;
      count_d  = '0;
      acc_d    = '0;
      result_d = '0;
      ovf_d    = 1'b0;
      pend_d   = PEND_ADD;
      state_d  = S_ENTRY_A;
    end else if (isArith) begin
      pend_d = newPend;
      if (state_q != S_OP_WAIT) begin
        entry_d = '0;
        count_d = '0;
        state_d = S_OP_WAIT;
      end
      case (state_q)
        S_ENTRY_A: acc_d = entry_q;
        S_ENTRY_B: begin
          acc_d      = calcVal;
          result_d   = calcVal;
          resValid_d = 1'b1;
          ovf_d      = ovf_q | calcOvf;
        end
        S_SHOW:    acc_d = result_q;
        default: ;
      endcase
    end else if (isEquals) begin
      // Equals after a bare first operand simply publishes that operand.
      if (state_q == S_ENTRY_A) begin
        result_d   = entry_q;
        resValid_d = 1'b1;
        entry_d    = '0;
        count_d    = '0;
        state_d    = S_SHOW;
      end else if (state_q == S_ENTRY_B) begin
        acc_d      = calcVal;
        result_d   = calcVal;
        resValid_d = 1'b1;
        ovf_d      = ovf_q | calcOvf;
        pend_d     = PEND_ADD;
        entry_d    = '0;
        count_d    = '0;
        state_d    = S_SHOW;
      end
    end
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      entry_q    <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      resValid_q <= 1'b0;
      ovf_q      <= 1'b0;
      pend_q     <= PEND_ADD;
      state_q    <= S_ENTRY_A;
    end else begin
      entry_q    <= entry_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      resValid_q <= resValid_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
    end
  end

  assign entry        = entry_q;
  assign digit_count  = count_q;
  assign result       = result_q;
  assign result_valid = resValid_q;
  assign overflow     = ovf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_calc_entry_core.sv
// Directed bench for calc_entry_core (MAX_DIGITS=3 so the digit limit is reachable).
module tb_calc_entry_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        digitValid;
  logic [3:0]  digitIn;
  logic        opValid;
  logic [2:0]  opIn;
  logic [31:0] entry;
  logic [3:0]  digitCount;
  logic [31:0] result;
  logic        resultValid;
  logic        overflow;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int pulseCount = 0;

  calc_entry_core #(.DATA_W(32), .MAX_DIGITS(3), .ENABLE_MUL(1)) dut (
    .CLK_100MHZ  (clk),
    .reset       (reset),
    .digit_valid (digitValid),
    .digit       (digitIn),
    .op_valid    (opValid),
    .op          (opIn),
    .entry       (entry),
    .digit_count (digitCount),
    .result      (result),
    .result_valid(resultValid),
    .overflow    (overflow),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resultValid === 1'b1) pulseCount++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change at a falling edge and outputs are read at the following one.
  task automatic applyStimulus(input logic dv, input logic [3:0] d, input logic ov, input logic [2:0] o);
    digitValid = dv;
    digitIn    = d;
    opValid    = ov;
    opIn       = o;
    @(negedge clk);
    digitValid = 1'b0;
    digitIn    = 4'd0;
    opValid    = 1'b0;
    opIn       = 3'd0;
  endtask

  task automatic pressDigit(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 3'd0);
  endtask

  task automatic pressOp(input logic [2:0] o);
    applyStimulus(1'b0, 4'd0, 1'b1, o);
  endtask

  initial begin
    reset = 1'b1;
    digitValid = 1'b0;
    digitIn = 4'd0;
    opValid = 1'b0;
    opIn = 3'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_entry", entry, 0);
    checkOutput("rst_count", digitCount, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_rv", resultValid, 0);
    checkOutput("rst_ovf", overflow, 0);
    reset = 1'b0;

    // 123 + 45 = 168
    pulseCount = 0;
    pressDigit(1); pressDigit(2); pressDigit(3);
    checkOutput("add_entryA", entry, 123);
    checkOutput("add_countA", digitCount, 3);
    pressOp(0);
    checkOutput("add_opwait", state, 1);
    checkOutput("add_entry_clr", entry, 0);
    pressDigit(4); pressDigit(5);
    checkOutput("add_entryB_state", state, 2);
    checkOutput("add_entryB", entry, 45);
    checkOutput("add_rv_before", resultValid, 0);
    pressOp(3);
    checkOutput("add_result", result, 168);
    checkOutput("add_rv", resultValid, 1);
    checkOutput("add_show", state, 3);
    checkOutput("add_ovf", overflow, 0);
    @(negedge clk);
    checkOutput("add_rv_drop", resultValid, 0);
    checkOutput("add_pulses", pulseCount, 1);

    // SHOW + add chains on the displayed result: 168 + 2 = 170
    pressOp(0);
    checkOutput("show_op_state", state, 1);
    pressDigit(2);
    pressOp(3);
    checkOutput("show_chain_result", result, 170);

    // Clear from SHOW, then the digit limit
    pressOp(4);
    checkOutput("clr_state", state, 0);
    checkOutput("clr_result", result, 0);
    checkOutput("clr_rv", resultValid, 0);
    pressDigit(9); pressDigit(9); pressDigit(9); pressDigit(9);
    checkOutput("lim_entry", entry, 999);
    checkOutput("lim_count", digitCount, 3);
    pressDigit(12);
    checkOutput("bad_digit_entry", entry, 999);
    checkOutput("bad_digit_count", digitCount, 3);

    // 5 - 7 wraps and sets overflow; a new digit from SHOW clears it
    pressOp(4);
    pressDigit(5); pressOp(1); pressDigit(7); pressOp(3);
    checkOutput("sub_result", result, 32'hFFFF_FFFE);
    checkOutput("sub_ovf", overflow, 1);
    pressDigit(3);
    checkOutput("sub_next_entry", entry, 3);
    checkOutput("sub_next_count", digitCount, 1);
    checkOutput("sub_next_ovf", overflow, 0);
    checkOutput("sub_next_state", state, 0);

    // 2 + 3 * 4 evaluated left to right: 5 then 20
    pressOp(4);
    pulseCount = 0;
    pressDigit(2); pressOp(0); pressDigit(3); pressOp(2);
    checkOutput("chain_r1", result, 5);
    checkOutput("chain_r1_rv", resultValid, 1);
    checkOutput("chain_r1_state", state, 1);
    pressDigit(4); pressOp(3);
    checkOutput("chain_r2", result, 20);
    @(negedge clk);
    checkOutput("chain_pulses", pulseCount, 2);

    // Digit and op together: op wins, accumulator holds 6
    pressOp(4);
    pressDigit(6);
    applyStimulus(1'b1, 4'd7, 1'b1, 3'd0);
    checkOutput("simul_state", state, 1);
    checkOutput("simul_entry", entry, 0);
    checkOutput("simul_count", digitCount, 0);
    pressOp(3);
    checkOutput("eq_opwait_ignored", state, 1);
    pressDigit(1); pressOp(3);
    checkOutput("simul_acc", result, 7);

    // Invalid op is ignored
    pressOp(4);
    pressDigit(1); pressDigit(2);
    pressOp(5);
    checkOutput("badop_state", state, 0);
    checkOutput("badop_entry", entry, 12);

    // 999^4 mod 2^32 with sticky overflow
    pressOp(4);
    pressDigit(9); pressDigit(9); pressDigit(9); pressOp(2);
    pressDigit(9); pressDigit(9); pressDigit(9); pressOp(2);
    checkOutput("mul_r1", result, 998001);
    checkOutput("mul_r1_ovf", overflow, 0);
    pressDigit(9); pressDigit(9); pressDigit(9); pressOp(2);
    pressDigit(9); pressDigit(9); pressDigit(9); pressOp(3);
    checkOutput("mul_result", result, 32'd3868550625);
    checkOutput("mul_ovf", overflow, 1);
    pressOp(0);
    checkOutput("mul_ovf_sticky", overflow, 1);
    pressOp(4);
    checkOutput("clr_ovf", overflow, 0);

    // Reset in the same cycle as equals in ENTRY_B
    pressDigit(8); pressOp(3);
    pressOp(0); pressDigit(2);
    checkOutput("pre_rst_state", state, 2);
    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b1, 3'd3);
    checkOutput("rst_eq_rv", resultValid, 0);
    checkOutput("rst_eq_result", result, 0);
    checkOutput("rst_eq_state", state, 0);
    checkOutput("rst_eq_entry", entry, 0);
    checkOutput("rst_eq_count", digitCount, 0);
    checkOutput("rst_eq_ovf", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
